// File: rtl/short_preamble_pkg.sv
// Shared types and helpers for the short-preamble (STS) detector front end.
package short_preamble_pkg;

  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned CORR_W   = 32;
  localparam int unsigned POWER_W  = 16;
  localparam int unsigned TERM_W   = 33;

  // One window entry: correlation term (re/im) and power term.
  typedef struct packed {
    logic signed [TERM_W-1:0] c_re;
    logic signed [TERM_W-1:0] c_im;
    logic signed [TERM_W-1:0] p;
  } term_t;

  function automatic logic [15:0] sat16(input logic signed [47:0] v);
    if (v > 48'sd32767)
      return 16'h7fff;
    else if (v < -48'sd32768)
      return 16'h8000;
    else
      return v[15:0];
  endfunction

endpackage

// File: rtl/short_preamble_autocorr_window_moving_sum.sv
// Ring buffer of LEN multi-lane terms with per-lane running sums; sum_next is the
// accumulator value after the current term is added and the oldest one retired.
module window_moving_sum #(
  parameter int unsigned LANE_W = 33,
  parameter int unsigned LANES  = 3,
  parameter int unsigned LEN    = 64,
  parameter int unsigned ACC_W  = LANE_W + $clog2(LEN)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [LANES*LANE_W-1:0]  term,
  output logic [LANES*ACC_W-1:0]   sum_next
);

  localparam int unsigned PTR_W = $clog2(LEN);

  logic [LANES*LANE_W-1:0] ring [LEN];
  logic [PTR_W-1:0]        ptr;
  logic [PTR_W:0]          fill;
  logic [LANES*ACC_W-1:0]  acc;
  logic                    full;

  assign full = (fill == (PTR_W + 1)'(LEN));

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic signed [LANE_W-1:0] new_t;
    logic signed [LANE_W-1:0] old_t;
    logic signed [ACC_W-1:0]  acc_l;
    assign new_t = term[l*LANE_W +: LANE_W];
    // Until the window has filled, the slot under ptr holds no retired term.
    assign old_t = full ? ring[ptr][l*LANE_W +: LANE_W] : '0;
    assign acc_l = acc[l*ACC_W +: ACC_W];
    assign sum_next[l*ACC_W +: ACC_W] = acc_l + ACC_W'(new_t) - ACC_W'(old_t);
  end

  always_ff @(posedge clk) begin
    if (en && !rst)
      ring[ptr] <= term;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr  <= '0;
      fill <= '0;
      acc  <= '0;
    end else if (en) begin
      ptr <= ptr + PTR_W'(1);
      if (!full)
        fill <= fill + (PTR_W + 1)'(1);
      acc <= sum_next;
    end
  end

endmodule

// File: rtl/short_preamble_autocorr.sv
// Delay-and-correlate STS front end: moving sums of x*conj(x[n-DELAY]) and |x|^2.
// Define SHORT_PREAMBLE_AUTOCORR_SATURATE_EN to clamp outputs instead of wrapping.
module short_preamble_autocorr
  import short_preamble_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DELAY      = 16,
  parameter int unsigned WINDOW_LEN = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic [WIDTH-1:0]   i_samples_tdata,
  input  logic               i_samples_tlast,
  input  logic               i_samples_tvalid,
  output logic               i_samples_tready,
  output logic [CORR_W-1:0]  o_corr_tdata,
  output logic               o_corr_tvalid,
  input  logic               o_corr_tready,
  output logic [POWER_W-1:0] o_power_tdata,
  output logic               o_power_tvalid,
  input  logic               o_power_tready,
  output logic [WIDTH-1:0]   o_samples_tdata,
  output logic               o_samples_tlast,
  output logic               o_samples_tvalid,
  input  logic               o_samples_tready
);

  localparam int unsigned LOG_WIN = $clog2(WINDOW_LEN);
  localparam int unsigned ACC_W   = TERM_W + LOG_WIN;
  localparam int unsigned SHIFT   = SAMPLE_W + LOG_WIN;
  localparam int unsigned DFILL_W = $clog2(DELAY + 1);

  logic rst, out_valid, enable, accept;

  assign rst              = reset | clear;
  assign enable           = ~out_valid | (o_corr_tready & o_power_tready & o_samples_tready);
  assign accept           = enable & i_samples_tvalid;
  assign i_samples_tready = enable;
  assign o_corr_tvalid    = out_valid;
  assign o_power_tvalid   = out_valid;
  assign o_samples_tvalid = out_valid;

  // Delay line (shift register, no reset; dfill masks stale contents).
  logic [WIDTH-1:0]   dline [DELAY];
  logic [DFILL_W-1:0] dfill;
  logic               dfull;

  assign dfull = (dfill == DFILL_W'(DELAY));

  always_ff @(posedge clk) begin
    if (accept && !rst) begin
      dline[0] <= i_samples_tdata;
      for (int unsigned i = 1; i < DELAY; i++)
        dline[i] <= dline[i-1];
    end
  end

  // S0: capture sample and its delayed partner.
  logic             v0, last0;
  logic [WIDTH-1:0] x0, d0;

  always_ff @(posedge clk) begin
    if (rst) begin
      v0    <= 1'b0;
      last0 <= 1'b0;
      x0    <= '0;
      d0    <= '0;
      dfill <= '0;
    end else if (enable) begin
      v0 <= i_samples_tvalid;
      if (i_samples_tvalid) begin
        x0    <= i_samples_tdata;
        d0    <= dfull ? dline[DELAY-1] : '0;
        last0 <= i_samples_tlast;
        if (!dfull)
          dfill <= dfill + DFILL_W'(1);
      end
    end
  end

  // S1: full-precision products.
  logic signed [SAMPLE_W-1:0]   xi, xq, di, dq;
  logic signed [2*SAMPLE_W-1:0] m_ii, m_qq, m_qi, m_iq, m_pi, m_pq;
  term_t                        term0, term1;
  logic                         v1, last1;
  logic [WIDTH-1:0]             x1;

  assign xi   = x0[WIDTH-1 -: SAMPLE_W];
  assign xq   = x0[SAMPLE_W-1:0];
  assign di   = d0[WIDTH-1 -: SAMPLE_W];
  assign dq   = d0[SAMPLE_W-1:0];
  assign m_ii = xi * di;
  assign m_qq = xq * dq;
  assign m_qi = xq * di;
  assign m_iq = xi * dq;
  assign m_pi = xi * xi;
  assign m_pq = xq * xq;

  assign term0.c_re = TERM_W'(m_ii) + TERM_W'(m_qq);
  assign term0.c_im = TERM_W'(m_qi) - TERM_W'(m_iq);
  assign term0.p    = TERM_W'(m_pi) + TERM_W'(m_pq);

  always_ff @(posedge clk) begin
    if (rst) begin
      v1    <= 1'b0;
      last1 <= 1'b0;
      x1    <= '0;
      term1 <= '0;
    end else if (enable) begin
      v1 <= v0;
      if (v0) begin
        x1    <= x0;
        last1 <= last0;
        term1 <= term0;
      end
    end
  end

  // S2: window accumulate, scale, register outputs.
  logic [3*ACC_W-1:0] sums;

  window_moving_sum #(
    .LANE_W (TERM_W),
    .LANES  (3),
    .LEN    (WINDOW_LEN),
    .ACC_W  (ACC_W)
  ) u_window (
    .clk      (clk),
    .rst      (rst),
    .en       (enable & v1),
    .term     (term1),
    .sum_next (sums)
  );

  function automatic logic [15:0] narrow(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    s = a >>> SHIFT;
`ifdef SHORT_PREAMBLE_AUTOCORR_SATURATE_EN
    return sat16(48'(s));
`else
    return s[15:0];
`endif
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid       <= 1'b0;
      o_corr_tdata    <= '0;
      o_power_tdata   <= '0;
      o_samples_tdata <= '0;
      o_samples_tlast <= 1'b0;
    end else if (enable) begin
      out_valid <= v1;
      if (v1) begin
        o_corr_tdata    <= {narrow(sums[2*ACC_W +: ACC_W]), narrow(sums[ACC_W +: ACC_W])};
        o_power_tdata   <= narrow(sums[0 +: ACC_W]);
        o_samples_tdata <= x1;
        o_samples_tlast <= last1;
      end
    end
  end

endmodule

// File: tb/tb_short_preamble_autocorr.sv
// Self-checking bench: windowed-sum reference model over the accepted-sample history.
module tb_short_preamble_autocorr;

  localparam int DLY = 16;
  localparam int WIN = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b0, clear = 1'b0;
  logic [31:0] i_samples_tdata = '0;
  logic        i_samples_tlast = 1'b0, i_samples_tvalid = 1'b0;
  logic        i_samples_tready;
  logic [31:0] o_corr_tdata;
  logic        o_corr_tvalid;
  logic        o_corr_tready = 1'b1;
  logic [15:0] o_power_tdata;
  logic        o_power_tvalid;
  logic        o_power_tready = 1'b1;
  logic [31:0] o_samples_tdata;
  logic        o_samples_tlast, o_samples_tvalid;
  logic        o_samples_tready = 1'b1;

  always #5 clk = ~clk;

  short_preamble_autocorr #(.WIDTH(32), .DELAY(DLY), .WINDOW_LEN(WIN)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .i_samples_tdata(i_samples_tdata), .i_samples_tlast(i_samples_tlast),
    .i_samples_tvalid(i_samples_tvalid), .i_samples_tready(i_samples_tready),
    .o_corr_tdata(o_corr_tdata), .o_corr_tvalid(o_corr_tvalid), .o_corr_tready(o_corr_tready),
    .o_power_tdata(o_power_tdata), .o_power_tvalid(o_power_tvalid), .o_power_tready(o_power_tready),
    .o_samples_tdata(o_samples_tdata), .o_samples_tlast(o_samples_tlast),
    .o_samples_tvalid(o_samples_tvalid), .o_samples_tready(o_samples_tready)
  );

  typedef struct {
    logic [31:0] c;
    logic [15:0] p;
    logic [31:0] s;
    logic        l;
  } exp_t;

  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   hx[$];
  int   hq[$];
  exp_t exp_q[$];
  logic [31:0] rx_corr [0:1023];
  logic [15:0] rx_pow  [0:1023];
  logic        rx_last [0:1023];
  int   rx_n = 0;
  logic pending = 1'b0;
  logic [31:0] held_corr;
  logic [15:0] held_pow;

  function automatic void chk(string name, longint act, longint req);
    total_cnt++;
    if (act == req) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endfunction

  function automatic void chk_range(string name, longint act, longint lo, longint hi);
    total_cnt++;
    if (act >= lo && act <= hi) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
  endfunction

  function automatic logic [15:0] nar(longint v);
`ifdef SHORT_PREAMBLE_AUTOCORR_SATURATE_EN
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
`endif
    return v[15:0];
  endfunction

  // Reference: direct sums over the last WIN accepted samples since reset.
  function automatic void model(output logic [31:0] c, output logic [15:0] p);
    longint cr = 0, ci = 0, pw = 0;
    int n = hx.size() - 1;
    int k0 = (n - WIN + 1 < 0) ? 0 : n - WIN + 1;
    for (int k = k0; k <= n; k++) begin
      pw += longint'(hx[k]) * hx[k] + longint'(hq[k]) * hq[k];
      if (k >= DLY) begin
        cr += longint'(hx[k]) * hx[k-DLY] + longint'(hq[k]) * hq[k-DLY];
        ci += longint'(hq[k]) * hx[k-DLY] - longint'(hx[k]) * hq[k-DLY];
      end
    end
    c = {nar(cr >>> 22), nar(ci >>> 22)};
    p = nar(pw >>> 22);
  endfunction

  function automatic longint s16(logic [15:0] v);
    return longint'($signed(v));
  endfunction

  always @(negedge clk) begin
    if (reset || clear) begin
      hx.delete(); hq.delete(); exp_q.delete();
      rx_n = 0;
      pending = 1'b0;
    end else begin
      logic xfer;
      exp_t e;
      chk("valid_lockstep_power", o_power_tvalid, o_corr_tvalid);
      chk("valid_lockstep_samples", o_samples_tvalid, o_corr_tvalid);
      if (pending) begin
        chk("valid_held", o_corr_tvalid, 1);
        chk("corr_held", o_corr_tdata, held_corr);
        chk("power_held", o_power_tdata, held_pow);
      end
      xfer = o_corr_tvalid && o_corr_tready && o_power_tready && o_samples_tready;
      if (xfer) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("corr", o_corr_tdata, e.c);
          chk("power", o_power_tdata, e.p);
          chk("samples", o_samples_tdata, e.s);
          chk("tlast", o_samples_tlast, e.l);
          if (rx_n < 1024) begin
            rx_corr[rx_n] = o_corr_tdata;
            rx_pow[rx_n]  = o_power_tdata;
            rx_last[rx_n] = o_samples_tlast;
          end
          rx_n++;
        end
      end
      pending   = o_corr_tvalid && !xfer;
      held_corr = o_corr_tdata;
      held_pow  = o_power_tdata;
      if (i_samples_tvalid && i_samples_tready) begin
        hx.push_back(int'($signed(i_samples_tdata[31:16])));
        hq.push_back(int'($signed(i_samples_tdata[15:0])));
        model(e.c, e.p);
        e.s = i_samples_tdata;
        e.l = i_samples_tlast;
        exp_q.push_back(e);
      end
    end
  end

  function automatic logic [31:0] gen(int kind, int n);
    real ph, vi, vq;
    logic [15:0] a, b;
    case (kind)
      0: return {16'd8192, 16'd0};
      1: begin
        ph = 2.0 * 3.14159265358979 * n / 64.0;
        vi = 8192.0 * $cos(ph);
        vq = 8192.0 * $sin(ph);
        a = 16'($rtoi(vi + (vi >= 0.0 ? 0.5 : -0.5)));
        b = 16'($rtoi(vq + (vq >= 0.0 ? 0.5 : -0.5)));
        return {a, b};
      end
      2: return $urandom;
      default: return {16'h8000, 16'h8000};
    endcase
  endfunction

  task automatic set_readys(bit rnd);
    o_corr_tready    = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    o_power_tready   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    o_samples_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic run_stream(int kind, int nsamp, bit rnd, int last_idx, bit drain);
    int n = 0;
    int cyc = 0;
    logic [31:0] cur = gen(kind, 0);
    while (n < nsamp) begin
      @(posedge clk); #1;
      i_samples_tvalid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      i_samples_tdata  = cur;
      i_samples_tlast  = (n == last_idx);
      set_readys(rnd);
      @(negedge clk);
      if (i_samples_tvalid && i_samples_tready) begin
        n++;
        cur = gen(kind, n);
      end
    end
    if (drain) begin
      @(posedge clk); #1;
      i_samples_tvalid = 1'b0;
      i_samples_tlast  = 1'b0;
      while (exp_q.size() > 0 && cyc < 2000) begin
        set_readys(rnd);
        @(posedge clk); #1;
        cyc++;
      end
      chk("drain_complete", exp_q.size(), 0);
      set_readys(1'b0);
    end
  endtask

  task automatic do_reset(bit use_clear);
    @(posedge clk); #1;
    i_samples_tvalid = 1'b0;
    if (use_clear) clear = 1'b1; else reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    clear = 1'b0;
    @(negedge clk);
    chk("rst_valid", o_corr_tvalid, 0);
    chk("rst_corr", o_corr_tdata, 0);
    chk("rst_power", o_power_tdata, 0);
    chk("rst_samples", o_samples_tdata, 0);
    chk("rst_tlast", o_samples_tlast, 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lasts;

    // DC (8192,0)
    do_reset(1'b0);
    run_stream(0, 100, 1'b0, -1, 1'b1);
    chk("dc_count", rx_n, 100);
    chk("dc_n0_corr", rx_corr[0], 0);
    chk("dc_n0_power", rx_pow[0], 16);
    chk("dc_n62_power", rx_pow[62], 1008);
    chk("dc_n63_power", rx_pow[63], 1024);
    chk("dc_n78_corr_i", s16(rx_corr[78][31:16]), 1008);
    chk("dc_n79_corr_i", s16(rx_corr[79][31:16]), 1024);
    chk("dc_n79_corr_q", s16(rx_corr[79][15:0]), 0);

    // Tone at fs/64
    do_reset(1'b0);
    run_stream(1, 128, 1'b0, -1, 1'b1);
    chk_range("tone_corr_i", s16(rx_corr[127][31:16]), -1, 1);
    chk_range("tone_corr_q", s16(rx_corr[127][15:0]), 1023, 1025);
    chk_range("tone_power", s16(rx_pow[127]), 1023, 1025);

    // Random data with random valid and backpressure
    do_reset(1'b0);
    run_stream(2, 200, 1'b1, -1, 1'b1);
    chk("rand_count", rx_n, 200);

    // Reset mid-stream
    do_reset(1'b0);
    run_stream(0, 40, 1'b0, -1, 1'b0);
    @(posedge clk); #1;
    i_samples_tvalid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_valid_low", o_corr_tvalid, 0);
    reset = 1'b0;
    run_stream(0, 20, 1'b0, -1, 1'b1);
    chk("midrst_n0_corr", rx_corr[0], 0);
    chk("midrst_n0_power", rx_pow[0], 16);

    // Full-scale corner (-32768,-32768)
    do_reset(1'b0);
    run_stream(3, 100, 1'b0, -1, 1'b1);
`ifdef SHORT_PREAMBLE_AUTOCORR_SATURATE_EN
    chk("fs_power", s16(rx_pow[99]), 32767);
    chk("fs_corr_i", s16(rx_corr[99][31:16]), 32767);
`else
    chk("fs_power", s16(rx_pow[99]), -32768);
    chk("fs_corr_i", s16(rx_corr[99][31:16]), -32768);
`endif
    chk("fs_corr_q", s16(rx_corr[99][15:0]), 0);

    // tlast on n=5 only, started from clear
    do_reset(1'b1);
    run_stream(0, 20, 1'b0, 5, 1'b1);
    lasts = 0;
    for (int i = 0; i < 20; i++) lasts += int'(rx_last[i]);
    chk("tlast_count", lasts, 1);
    chk("tlast_n5", rx_last[5], 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
